// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder: FSM states,
// read-source select, default parameters and the word-index width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RD_DONE = 2'd2,
        WR_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_LED  = 2'd2
    } rd_sel_t;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
    localparam logic [31:0] DEFAULT_LED_ADDR    = 32'h0000_2000;

    function automatic int unsigned idx_width(input int unsigned depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: strobes, address/data from cpu, load data and ready back.
interface data_mem_responder_if;

    logic [31:0] addr;
    logic [31:0] write_data;
    logic        memwrite;
    logic        memread;
    logic [31:0] read_data;
    logic        ready;

    modport master (
        output addr, write_data, memwrite, memread,
        input  read_data, ready
    );

    modport slave (
        input  addr, write_data, memwrite, memread,
        output read_data, ready
    );

endinterface

// File: rtl/dmem_bram.sv
// Single-port synchronous word RAM, write-first, one-cycle registered read.
module dmem_bram
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic                              clk,
    input  logic                              en,
    input  logic                              we,
    input  logic [idx_width(DEPTH_WORDS)-1:0] idx,
    input  logic [31:0]                       wdata,
    output logic [31:0]                       rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[idx] <= wdata;
                rdata_q  <= wdata;
            end else begin
                rdata_q  <= mem[idx];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: services cpu loads/stores from dmem_bram and hosts an
// optional LED register (enabled with `define DMEM_LED_EN).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [31:0] LED_ADDR    = DEFAULT_LED_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic [7:0]           led
);

    localparam int unsigned AW = idx_width(DEPTH_WORDS);

`ifdef DMEM_LED_EN
    localparam logic LED_EN = 1'b1;
`else
    localparam logic LED_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    rd_sel_t     rd_sel_q, rd_sel_d;
    logic [31:0] read_data_q, read_data_d;
    logic [7:0]  led_q, led_d;

    logic [29:0]   word_addr;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          is_led;
    logic          accept_wr;
    logic          accept_rd;
    logic          ram_en;
    logic          ram_we;
    logic          ready;
    logic [31:0]   ram_rdata;
    logic          unused_addr_bits;

    // Byte lane bits are ignored: every access is aligned down to its word.
    assign word_addr        = bus.addr[31:2];
    assign word_idx         = bus.addr[AW+1:2];
    assign unused_addr_bits = ^bus.addr[1:0];
    assign in_range         = (word_addr >> AW) == 30'd0;
    assign is_led           = LED_EN && (word_addr == LED_ADDR[31:2]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Write has priority over a simultaneous read; the read is simply dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.memwrite) begin
                    state_d = WR_DONE;
                end else if (bus.memread) begin
                    state_d = RD_WAIT;
                end
            end
            RD_WAIT: state_d = RD_DONE;
            RD_DONE: state_d = IDLE;
            WR_DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        accept_wr = (state_q == IDLE) && bus.memwrite;
        accept_rd = (state_q == IDLE) && !bus.memwrite && bus.memread;
        ram_we    = accept_wr && in_range && !is_led;
        ram_en    = ram_we || (accept_rd && in_range && !is_led);
        ready     = (state_q == RD_DONE) || (state_q == WR_DONE);
    end

    always_comb begin
        rd_sel_d    = rd_sel_q;
        read_data_d = read_data_q;
        led_d       = led_q;
        if (accept_rd) begin
            if (is_led) begin
                rd_sel_d = SEL_LED;
            end else if (in_range) begin
                rd_sel_d = SEL_RAM;
            end else begin
                rd_sel_d = SEL_ZERO;
            end
        end
        if (state_q == RD_WAIT) begin
            case (rd_sel_q)
                SEL_RAM: read_data_d = ram_rdata;
                SEL_LED: read_data_d = {24'h0, led_q};
                default: read_data_d = '0;
            endcase
        end
        if (accept_wr && is_led) begin
            led_d = bus.write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel_q    <= SEL_ZERO;
            read_data_q <= '0;
            led_q       <= '0;
        end else begin
            rd_sel_q    <= rd_sel_d;
            read_data_q <= read_data_d;
            led_q       <= led_d;
        end
    end

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (word_idx),
        .wdata (bus.write_data),
        .rdata (ram_rdata)
    );

    assign bus.read_data = read_data_q;
    assign bus.ready     = ready;

`ifdef DMEM_LED_EN
    assign led = led_q;
`else
    assign led = '0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected latency/data queued per request.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 1024;

    typedef struct {
        int          lat;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] led;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LED_ADDR    (32'h0000_2000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .led (led)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Issues one request from a negedge; returns the ready latency in cycles
    // after acceptance (-1 on timeout) and whether ready lingered a second cycle.
    task automatic drive_req(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, output int lat,
                             output logic [31:0] rdata, output logic extra);
        lat   = -1;
        rdata = '0;
        bus.addr       = a;
        bus.write_data = d;
        bus.memwrite   = wr;
        bus.memread    = rd;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat   = c;
                rdata = bus.read_data;
                break;
            end
        end
        bus.memwrite = 1'b0;
        bus.memread  = 1'b0;
        @(negedge clk);
        extra = bus.ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready cyc%0d: got %b want 0", i, bus.ready); end
            n_cmp++; if (bus.read_data !== 32'h0) begin n_bad++; $display("FAIL reset_rdata cyc%0d: got %h want 0", i, bus.read_data); end
            n_cmp++; if (led !== 8'h0) begin n_bad++; $display("FAIL reset_led cyc%0d: got %h want 0", i, led); end
        end
    endtask

    task automatic test_write_read();
        int lat; logic [31:0] rd; logic ex; exp_t e;
        logic [31:0] addrs [3];
        logic        isw   [3];
        addrs = '{32'h10, 32'h10, 32'h13};
        isw   = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{isw[i] ? 1 : 2, !isw[i], 32'hDEAD_BEEF});
            drive_req(isw[i], !isw[i], addrs[i], 32'hDEAD_BEEF, lat, rd, ex);
            e = sb.pop_front();
            n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL wr_rd_lat[%0d]: got %0d want %0d", i, lat, e.lat); end
            n_cmp++; if (ex !== 1'b0) begin n_bad++; $display("FAIL wr_rd_pulse[%0d]: ready got %b want 0", i, ex); end
            if (e.chk_data) begin
                n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL wr_rd_data[%0d]: got %h want %h", i, rd, e.data); end
            end
        end
    endtask

    task automatic test_simultaneous();
        int lat; logic [31:0] rd; logic ex; exp_t e;
        sb.push_back('{1, 1'b0, 32'h0});
        drive_req(1'b1, 1'b1, 32'h20, 32'h0000_1234, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL simul_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (ex !== 1'b0) begin n_bad++; $display("FAIL simul_single_ready: got %b want 0", ex); end
        n_cmp++; if (bus.read_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL simul_rdata_hold: got %h want deadbeef", bus.read_data); end
        sb.push_back('{2, 1'b1, 32'h0000_1234});
        drive_req(1'b0, 1'b1, 32'h20, 32'h0, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL simul_rd_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL simul_rd_data: got %h want %h", rd, e.data); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic ex; exp_t e;
        drive_req(1'b1, 1'b0, 32'h0, 32'hA5A5_0000, lat, rd, ex);
        sb.push_back('{1, 1'b0, 32'h0});
        drive_req(1'b1, 1'b0, DEPTH * 4, 32'hFFFF_FFFF, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL oor_wr_lat: got %0d want %0d", lat, e.lat); end
        sb.push_back('{2, 1'b1, 32'h0});
        drive_req(1'b0, 1'b1, DEPTH * 4, 32'h0, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL oor_rd_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL oor_rd_data: got %h want %h", rd, e.data); end
        sb.push_back('{2, 1'b1, 32'hA5A5_0000});
        drive_req(1'b0, 1'b1, 32'h0, 32'h0, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL oor_word0: got %h want %h", rd, e.data); end
    endtask

    task automatic test_led();
        int lat; logic [31:0] rd; logic ex; exp_t e;
        logic [7:0]  led_exp;
        logic [31:0] rd_exp;
`ifdef DMEM_LED_EN
        led_exp = 8'hA5;
        rd_exp  = 32'h0000_00A5;
`else
        led_exp = 8'h00;
        rd_exp  = 32'h0;
`endif
        bus.addr       = 32'h0000_2000;
        bus.write_data = 32'h0000_01A5;
        bus.memwrite   = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b1) begin n_bad++; $display("FAIL led_wr_ready: got %b want 1", bus.ready); end
        n_cmp++; if (led !== led_exp) begin n_bad++; $display("FAIL led_value: got %h want %h", led, led_exp); end
        bus.memwrite = 1'b0;
        @(negedge clk);
        sb.push_back('{2, 1'b1, rd_exp});
        drive_req(1'b0, 1'b1, 32'h0000_2000, 32'h0, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL led_rd_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL led_rd_data: got %h want %h", rd, e.data); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] rd; logic ex; exp_t e;
        int pulses;
        int last;
        drive_req(1'b1, 1'b0, 32'h40, 32'h0BAD_F00D, lat, rd, ex);
        for (int i = 0; i < 4; i++) sb.push_back('{3, 1'b1, 32'h0BAD_F00D});
        bus.addr    = 32'h40;
        bus.memread = 1'b1;
        pulses = 0;
        last   = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.ready) begin
                pulses++;
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL b2b_rd_extra: got response %0d want none", pulses);
                end else begin
                    e = sb.pop_front();
                    n_cmp++; if (bus.read_data !== e.data) begin n_bad++; $display("FAIL b2b_rd_data: got %h want %h", bus.read_data, e.data); end
                    if (last >= 0) begin
                        n_cmp++; if (c - last !== e.lat) begin n_bad++; $display("FAIL b2b_rd_period: got %0d want %0d", c - last, e.lat); end
                    end
                end
                last = c;
            end
        end
        bus.memread = 1'b0;
        n_cmp++; if (pulses !== 4) begin n_bad++; $display("FAIL b2b_rd_count: got %0d want 4", pulses); end
        sb.delete();
        repeat (2) @(negedge clk);
        bus.addr       = 32'h44;
        bus.write_data = 32'h5555_AAAA;
        bus.memwrite   = 1'b1;
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        bus.memwrite = 1'b0;
        n_cmp++; if (pulses !== 6) begin n_bad++; $display("FAIL b2b_wr_count: got %0d want 6", pulses); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic ex; exp_t e;
        bus.addr    = 32'h10;
        bus.memread = 1'b1;
        @(negedge clk);
        n_cmp++; if (dut.state_q !== RD_WAIT) begin n_bad++; $display("FAIL rstmid_pre_state: got %0d want %0d", dut.state_q, RD_WAIT); end
        bus.memread = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0", bus.ready); end
        n_cmp++; if (dut.state_q !== IDLE) begin n_bad++; $display("FAIL rstmid_state: got %0d want %0d", dut.state_q, IDLE); end
        n_cmp++; if (bus.read_data !== 32'h0) begin n_bad++; $display("FAIL rstmid_rdata: got %h want 0", bus.read_data); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready2: got %b want 0", bus.ready); end
        sb.push_back('{2, 1'b1, 32'hDEAD_BEEF});
        drive_req(1'b0, 1'b1, 32'h10, 32'h0, lat, rd, ex);
        e = sb.pop_front();
        n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL rstmid_rd_lat: got %0d want %0d", lat, e.lat); end
        n_cmp++; if (rd !== e.data) begin n_bad++; $display("FAIL rstmid_rd_data: got %h want %h", rd, e.data); end
    endtask

    initial begin
        bus.addr       = '0;
        bus.write_data = '0;
        bus.memwrite   = 1'b0;
        bus.memread    = 1'b0;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_simultaneous();
        test_out_of_range();
        test_led();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
